// File: rtl/ysyx_24110015_bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_bp_pkg
// Description : Shared types, counter encodings and helpers for the
//               bimodal BTB next-PC predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24110015_bp_pkg;

  // Control-transfer class stored per BTB entry
  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_RET  = 2'd3
  } br_type_t;

  // 2-bit direction counter encodings: weakly taken / strongly taken
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;

  // Saturating up/down step of a 2-bit direction counter
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24110015_ras.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_ras
// Description : Non-speculative return address stack. Push on overflow wraps
//               and overwrites the oldest entry; pop on empty is ignored;
//               simultaneous push+pop replaces the top in place.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24110015_ras
  import ysyx_24110015_bp_pkg::*;
#(
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [31:0]                push_data,
  output logic [31:0]                top,
  output logic [$clog2(RAS_DEPTH):0] cnt
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [31:0]   stack [RAS_DEPTH];

  // ptr always addresses the most recent entry; it wraps naturally mod depth
  assign ptr_inc = ptr + PW'(1);
  assign top     = stack[ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr_inc;
      if (cnt != FULL) cnt <= cnt + (PW+1)'(1);
    end else if (pop && !push && (cnt != '0)) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  end

  // Stack storage is not reset; occupancy alone decides whether it is used
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && !pop)     stack[ptr_inc] <= push_data;
      else if (push && pop) stack[ptr]     <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24110015_bimodal_btb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24110015_bimodal_btb
// Description : Direct-mapped BTB with 2-bit direction counters, per-entry
//               transfer type and an optional return address stack.
//               Lookup is combinational; training is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24110015_bimodal_btb
  import ysyx_24110015_bp_pkg::*;
#(
  parameter int BLOCK_NUM  = 8,
  parameter int RAS_DEPTH  = 4,
  parameter bit ENABLE_RAS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] pc_predict,
  output logic        pc_predict_valid,
  input  logic        update_valid,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic        taken,
  input  logic        is_call,
  input  logic        is_ret,
  input  logic [31:0] pc_update,
  input  logic [31:0] target_addr
);

  localparam int IW = $clog2(BLOCK_NUM);
  localparam int TW = 32 - IW - 2;
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [BLOCK_NUM-1:0] valid_q;
  logic [TW-1:0]        tag_q    [BLOCK_NUM];
  logic [31:0]          target_q [BLOCK_NUM];
  logic [1:0]           ctr_q    [BLOCK_NUM];
  br_type_t             type_q   [BLOCK_NUM];

  logic [31:0]   ras_top;
  logic [CW-1:0] ras_cnt;

  // ---------------- lookup ----------------
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;

  assign lk_idx = pc_in[IW+1:2];
  assign lk_tag = pc_in[31:IW+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  // Returns prefer the RAS; other hits redirect only when predicted taken
  always_comb begin
    pc_predict       = pc_in + 32'd4;
    pc_predict_valid = 1'b0;
    if (lk_hit && (type_q[lk_idx] == BR_RET) && (ras_cnt != '0)) begin
      pc_predict       = ras_top;
      pc_predict_valid = 1'b1;
    end else if (lk_hit && ctr_q[lk_idx][1]) begin
      pc_predict       = target_q[lk_idx];
      pc_predict_valid = 1'b1;
    end
  end

  // ---------------- training ----------------
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic          up_hit;
  logic          up_any;
  br_type_t      up_type;
  logic          wr_entry;
  logic          wr_target;
  logic          wr_ctr;
  logic [1:0]    up_ctr;

  assign up_idx = pc_update[IW+1:2];
  assign up_tag = pc_update[31:IW+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_any = update_valid && (branch || jal || jalr);

  // Classify the resolved instruction and decide which entry fields change
  always_comb begin
    up_type   = BR_COND;
    wr_entry  = 1'b0;
    wr_target = 1'b0;
    wr_ctr    = 1'b0;
    up_ctr    = CTR_ST;
    if (branch)             up_type = BR_COND;
    else if (jal)           up_type = BR_JAL;
    else if (jalr && is_ret) up_type = BR_RET;
    else                    up_type = BR_JALR;

    if (up_any) begin
      if (branch) begin
        // Not-taken misses never allocate; hits only move the counter
        wr_entry  = !up_hit && taken;
        wr_target = taken;
        wr_ctr    = up_hit || taken;
        up_ctr    = up_hit ? ctr_next(ctr_q[up_idx], taken) : CTR_WT;
      end else begin
        wr_entry  = 1'b1;
        wr_target = 1'b1;
        wr_ctr    = 1'b1;
        up_ctr    = CTR_ST;
      end
    end
  end

  // Valid bits are the only table state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_entry) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload arrays: written on training, left untouched by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_entry) begin
        tag_q[up_idx]  <= up_tag;
        type_q[up_idx] <= up_type;
      end
      if (wr_target) target_q[up_idx] <= target_addr;
      if (wr_ctr)    ctr_q[up_idx]    <= up_ctr;
    end
  end

  // ---------------- return address stack ----------------
  logic ras_push;
  logic ras_pop;

  assign ras_push = update_valid && (jal || jalr) && is_call;
  assign ras_pop  = update_valid && jalr && is_ret;

  generate
    if (ENABLE_RAS) begin : g_ras
      ysyx_24110015_ras #(
        .RAS_DEPTH(RAS_DEPTH)
      ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_update + 32'd4),
        .top      (ras_top),
        .cnt      (ras_cnt)
      );
    end else begin : g_no_ras
      assign ras_top = '0;
      assign ras_cnt = '0;
    end
  endgenerate

endmodule
`default_nettype wire
